// File: rtl/coproc_block_mover.sv
// Block mover control stage for the coprocessor memory.
// Waits for a rising start edge in the config word (cell 0) and checks the requested regions.
// It then copies `count` blocks of `blocks` cells from src to dst, strictly forward.
// Progress and result are reported through the status word (cell 1) and the busy/done/irq outputs.
module coproc_block_mover #(
  parameter int unsigned size       = 1024,
  parameter int unsigned blocks     = 4,
  parameter int unsigned log_size   = 10,
  parameter int unsigned cell_width = 32,
  parameter int unsigned width      = blocks * cell_width
) (
  input  logic                  in_clk,
  input  logic                  in_reset,
  input  logic [cell_width-1:0] in_config,
  input  logic [width-1:0]      in_mem_data,
  output logic [log_size-1:0]   out_address,
  output logic [width-1:0]      out_data,
  output logic                  out_read_en,
  output logic                  out_write_en,
  output logic [cell_width-1:0] out_status,
  output logic                  out_write_status_en,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_irq
);

  // Range checks need headroom above log_size so that src + blocks*count cannot wrap.
  localparam int unsigned ext_w = log_size + 3;

  localparam logic [cell_width-1:0] status_busy  = cell_width'(1);
  localparam logic [cell_width-1:0] status_error = cell_width'(6);

  typedef enum logic [2:0] {
    StIdle, StCheck, StRead, StCapture, StWrite, StDone, StError
  } state_t;

  state_t              state;
  logic                start_prev;
  logic [log_size-1:0] src, dst, count, k;

  logic                  start_edge;
  logic [log_size-1:0]   cfg_src, cfg_dst, cfg_count;
  logic [log_size-1:0]   k_next, cur_off, nxt_off;
  logic [ext_w-1:0]      span, src_end, dst_end;
  logic                  range_err;
  logic [cell_width-1:0] done_status;
  logic                  unused_cfg;

  assign cfg_src    = in_config[log_size:1];
  assign cfg_dst    = in_config[2*log_size:log_size+1];
  assign cfg_count  = in_config[3*log_size:2*log_size+1];
  assign unused_cfg = ^in_config[cell_width-1:3*log_size+1];
  assign start_edge = in_config[0] & ~start_prev;

  // Block offsets, range check against the latched job, and the completion status word.
  always_comb begin
    k_next    = k + log_size'(1);
    cur_off   = log_size'(blocks) * k;
    nxt_off   = log_size'(blocks) * k_next;
    span      = ext_w'(count) * ext_w'(blocks);
    src_end   = ext_w'(src) + span;
    dst_end   = ext_w'(dst) + span;
    range_err = (src_end > ext_w'(size)) || (dst_end > ext_w'(size)) || (dst < log_size'(2));
    done_status                 = '0;
    done_status[1]              = 1'b1;
    done_status[16 +: log_size] = count;
  end

  // Control FSM; outputs are registered and loaded on entry to the state they belong to.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state               <= StIdle;
      start_prev          <= 1'b1;
      src                 <= '0;
      dst                 <= '0;
      count               <= '0;
      k                   <= '0;
      out_address         <= '0;
      out_data            <= '0;
      out_read_en         <= 1'b0;
      out_write_en        <= 1'b0;
      out_status          <= '0;
      out_write_status_en <= 1'b0;
      out_busy            <= 1'b0;
      out_done            <= 1'b0;
      out_irq             <= 1'b0;
    end else begin
      start_prev          <= in_config[0];
      // Single-cycle strobes and buses default low; each state entry re-asserts what it needs.
      out_address         <= '0;
      out_data            <= '0;
      out_read_en         <= 1'b0;
      out_write_en        <= 1'b0;
      out_status          <= '0;
      out_write_status_en <= 1'b0;
      out_irq             <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start_edge) begin
            src                 <= cfg_src;
            dst                 <= cfg_dst;
            count               <= cfg_count;
            k                   <= '0;
            out_done            <= 1'b0;
            out_busy            <= 1'b1;
            out_write_status_en <= 1'b1;
            out_status          <= status_busy;
            state               <= StCheck;
          end
        end
        StCheck: begin
          if (range_err) begin
            out_busy            <= 1'b0;
            out_write_status_en <= 1'b1;
            out_status          <= status_error;
            out_irq             <= 1'b1;
            out_done            <= 1'b1;
            state               <= StError;
          end else if (count == '0) begin
            out_busy            <= 1'b0;
            out_write_status_en <= 1'b1;
            out_status          <= done_status;
            out_irq             <= 1'b1;
            out_done            <= 1'b1;
            state               <= StDone;
          end else begin
            out_read_en <= 1'b1;
            out_address <= src + cur_off;
            state       <= StRead;
          end
        end
        StRead: begin
          state <= StCapture;
        end
        StCapture: begin
          // Read data is valid this cycle; the write data register doubles as the block buffer.
          out_write_en <= 1'b1;
          out_address  <= dst + cur_off;
          out_data     <= in_mem_data;
          state        <= StWrite;
        end
        StWrite: begin
          k <= k_next;
          if (k_next == count) begin
            out_busy            <= 1'b0;
            out_write_status_en <= 1'b1;
            out_status          <= done_status;
            out_irq             <= 1'b1;
            out_done            <= 1'b1;
            state               <= StDone;
          end else begin
            out_read_en <= 1'b1;
            out_address <= src + nxt_off;
            state       <= StRead;
          end
        end
        StDone, StError: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
